// File: rtl/isa_pkg.sv
// isa_pkg: opcode constants, instruction field slices and sequencer state encoding
// shared by the fetch sequencer and the decoder stage.
package isa_pkg;

    localparam logic [3:0] OP_JMP = 4'hA;
    localparam logic [3:0] OP_BRZ = 4'hB;
    localparam logic [3:0] OP_HLT = 4'hF;

    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int TGT_HI = 6;
    localparam int TGT_LO = 0;
    localparam int TGT_W  = TGT_HI - TGT_LO + 1;

    localparam logic [7:0] END_ADDR_DEF = 8'd127;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        ADVANCE,
        HALT
    } state_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational control-flow decode of one instruction word;
// also used by the downstream decoder stage.
module instr_decode
    import isa_pkg::*;
#(
    parameter int IW = 16
) (
    input  logic [IW-1:0]    instr,
    input  logic             zero_flag,
    output logic             is_jmp,
    output logic             is_brz_taken,
    output logic             is_hlt,
    output logic [TGT_W-1:0] target
);

    logic [3:0] op;
    logic       unused_bits;

    assign op           = instr[OP_HI:OP_LO];
    assign is_jmp       = op == OP_JMP;
    assign is_brz_taken = op == OP_BRZ && zero_flag;
    assign is_hlt       = op == OP_HLT;
    assign target       = instr[TGT_HI:TGT_LO];
    assign unused_bits  = ^instr[OP_LO-1:TGT_HI+1];

endmodule

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: steps the PC through fetch (mem req/ack), issue (valid/ready)
// and a one-cycle advance that releases hold with jump/branch strobes.
module fetch_sequencer
    import isa_pkg::*;
#(
    parameter int             IW       = 16,
    parameter int             AW       = 8,
    parameter logic [AW-1:0]  END_ADDR = AW'(END_ADDR_DEF)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [AW-1:0]    pc_addr,
    output logic             hold,
    output logic             jump,
    output logic             branch,
    output logic [TGT_W-1:0] jump_line,
    output logic [TGT_W-1:0] branch_immem,
    output logic             mem_req,
    output logic [AW-1:0]    mem_addr,
    input  logic             mem_ack,
    input  logic [IW-1:0]    mem_rdata,
    input  logic             zero_flag,
    output logic [IW-1:0]    instr,
    output logic             instr_valid,
    input  logic             instr_ready,
    output logic             halted
);

    state_t           state_q, state_d;
    logic             hold_q, hold_d;
    logic             jump_q, jump_d;
    logic             branch_q, branch_d;
    logic [TGT_W-1:0] jump_line_q, jump_line_d;
    logic [TGT_W-1:0] branch_immem_q, branch_immem_d;
    logic             mem_req_q, mem_req_d;
    logic [AW-1:0]    mem_addr_q, mem_addr_d;
    logic [IW-1:0]    instr_q, instr_d;
    logic             instr_valid_q, instr_valid_d;
    logic             halted_q, halted_d;

    logic             dec_jmp, dec_brz_taken, dec_hlt;
    logic [TGT_W-1:0] dec_target;
    logic [IW-1:0]    dec_in;

    // In FETCH the decoder looks at the incoming word (halt detect), otherwise at the held one.
    assign dec_in = state_q == FETCH ? mem_rdata : instr_q;

    instr_decode #(.IW(IW)) u_dec (
        .instr       (dec_in),
        .zero_flag   (zero_flag),
        .is_jmp      (dec_jmp),
        .is_brz_taken(dec_brz_taken),
        .is_hlt      (dec_hlt),
        .target      (dec_target)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        jump_d         = jump_q;
        branch_d       = branch_q;
        jump_line_d    = jump_line_q;
        branch_immem_d = branch_immem_q;
        mem_req_d      = mem_req_q;
        mem_addr_d     = mem_addr_q;
        instr_d        = instr_q;
        instr_valid_d  = instr_valid_q;
        halted_d       = halted_q;
        unique case (state_q)
            IDLE: begin
                state_d    = FETCH;
                mem_req_d  = 1'b1;
                mem_addr_d = pc_addr;
            end
            FETCH: if (mem_ack) begin
                instr_d   = mem_rdata;
                mem_req_d = 1'b0;
                if (dec_hlt || pc_addr == END_ADDR) begin
                    state_d  = HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d       = ISSUE;
                    instr_valid_d = 1'b1;
                end
            end
            ISSUE: if (instr_valid_q && instr_ready) begin
                state_d        = ADVANCE;
                instr_valid_d  = 1'b0;
                hold_d         = 1'b0;
                jump_d         = dec_jmp;
                branch_d       = dec_brz_taken;
                jump_line_d    = dec_jmp ? dec_target : jump_line_q;
                branch_immem_d = instr_q[OP_HI:OP_LO] == OP_BRZ ? dec_target : branch_immem_q;
            end
            ADVANCE: begin
                state_d   = FETCH;
                hold_d    = 1'b1;
                jump_d    = 1'b0;
                branch_d  = 1'b0;
                mem_req_d = 1'b1;
                // The PC moves on this same edge, so present the address it is moving to.
                mem_addr_d = jump_q   ? AW'(jump_line_q) :
                             branch_q ? AW'(branch_immem_q) : mem_addr_q + AW'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            hold_q         <= 1'b1;
            jump_q         <= 1'b0;
            branch_q       <= 1'b0;
            jump_line_q    <= '0;
            branch_immem_q <= '0;
            mem_req_q      <= 1'b0;
            mem_addr_q     <= '0;
            instr_q        <= '0;
            instr_valid_q  <= 1'b0;
            halted_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            jump_q         <= jump_d;
            branch_q       <= branch_d;
            jump_line_q    <= jump_line_d;
            branch_immem_q <= branch_immem_d;
            mem_req_q      <= mem_req_d;
            mem_addr_q     <= mem_addr_d;
            instr_q        <= instr_d;
            instr_valid_q  <= instr_valid_d;
            halted_q       <= halted_d;
        end
    end

    assign hold         = hold_q;
    assign jump         = jump_q;
    assign branch       = branch_q;
    assign jump_line    = jump_line_q;
    assign branch_immem = branch_immem_q;
    assign mem_req      = mem_req_q;
    assign mem_addr     = mem_addr_q;
    assign instr        = instr_q;
    assign instr_valid  = instr_valid_q;
    assign halted       = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed bench with a small PC model driven by hold/jump/branch.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [7:0]  pc_addr;
    logic        hold, jump, branch;
    logic [6:0]  jump_line, branch_immem;
    logic        mem_req;
    logic [7:0]  mem_addr;
    logic        mem_ack;
    logic [15:0] mem_rdata;
    logic        zero_flag;
    logic [15:0] instr;
    logic        instr_valid, instr_ready, halted;

    int          n_chk  = 0;
    int          n_fail = 0;
    int          adv_cnt = 0;
    logic [7:0]  pc, pc_init;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .pc_addr     (pc_addr),
        .hold        (hold),
        .jump        (jump),
        .branch      (branch),
        .jump_line   (jump_line),
        .branch_immem(branch_immem),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_ack     (mem_ack),
        .mem_rdata   (mem_rdata),
        .zero_flag   (zero_flag),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .halted      (halted)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc <= pc_init;
        else if (!hold) pc <= jump ? {1'b0, jump_line} : branch ? {1'b0, branch_immem} : pc + 8'd1;
    end
    assign pc_addr = pc;

    always_ff @(posedge clk) if (reset_n && !hold) adv_cnt <= adv_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic run_instr(input logic [15:0] d, input int ack_dly, input int rdy_dly, input logic zf,
                             input logic ej, input logic eb, input logic [7:0] enext);
        int a0;
        repeat (ack_dly) begin
            chk("stall_req", 32'(mem_req), 1);
            chk("stall_addr", 32'(mem_addr), 32'(pc));
            chk("stall_hold", 32'(hold), 1);
            step();
        end
        chk("fetch_req", 32'(mem_req), 1);
        chk("fetch_addr", 32'(mem_addr), 32'(pc));
        mem_ack   = 1'b1;
        mem_rdata = d;
        step();
        mem_ack   = 1'b0;
        mem_rdata = ~d;
        a0 = adv_cnt;
        repeat (rdy_dly) begin
            chk("wait_valid", 32'(instr_valid), 1);
            chk("wait_instr", 32'(instr), 32'(d));
            chk("wait_hold", 32'(hold), 1);
            step();
        end
        chk("issue_valid", 32'(instr_valid), 1);
        chk("issue_instr", 32'(instr), 32'(d));
        chk("issue_req", 32'(mem_req), 0);
        instr_ready = 1'b1;
        zero_flag   = zf;
        step();
        instr_ready = 1'b0;
        zero_flag   = ~zf;
        chk("adv_hold", 32'(hold), 0);
        chk("adv_jump", 32'(jump), 32'(ej));
        chk("adv_branch", 32'(branch), 32'(eb));
        chk("adv_valid", 32'(instr_valid), 0);
        if (ej) chk("jump_line", 32'(jump_line), 32'(d[6:0]));
        if (d[15:12] == 4'hB) chk("branch_immem", 32'(branch_immem), 32'(d[6:0]));
        step();
        chk("next_hold", 32'(hold), 1);
        chk("next_req", 32'(mem_req), 1);
        chk("next_addr", 32'(mem_addr), 32'(enext));
        chk("next_pc", 32'(pc), 32'(enext));
        chk("adv_once", 32'(adv_cnt - a0), 1);
    endtask

    initial begin
        reset_n = 1'b0; pc_init = 8'd0; mem_ack = 1'b0; mem_rdata = '0;
        zero_flag = 1'b0; instr_ready = 1'b0;
        repeat (3) step();
        chk("rst_hold", 32'(hold), 1);
        chk("rst_req", 32'(mem_req), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_valid", 32'(instr_valid), 0);
        chk("rst_jump", 32'(jump), 0);
        chk("rst_branch", 32'(branch), 0);
        chk("rst_jline", 32'(jump_line), 0);
        reset_n = 1'b1;
        #1 chk("idle_req", 32'(mem_req), 0);
        step();
        chk("first_req", 32'(mem_req), 1);
        chk("first_addr", 32'(mem_addr), 0);

        run_instr(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 8'd1);
        run_instr(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 8'd2);
        run_instr(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 8'd3);
        run_instr(16'hA045, 0, 0, 1'b0, 1'b1, 1'b0, 8'h45);
        run_instr(16'hB012, 0, 0, 1'b1, 1'b0, 1'b1, 8'h12);
        chk("jline_held", 32'(jump_line), 32'h45);
        run_instr(16'hB012, 0, 0, 1'b0, 1'b0, 1'b0, 8'h13);
        run_instr(16'h1000, 4, 3, 1'b0, 1'b0, 1'b0, 8'h14);

        chk("hlt_addr", 32'(mem_addr), 32'h14);
        mem_ack = 1'b1; mem_rdata = 16'hF000;
        step();
        chk("hlt_halted", 32'(halted), 1);
        chk("hlt_req", 32'(mem_req), 0);
        chk("hlt_valid", 32'(instr_valid), 0);
        chk("hlt_hold", 32'(hold), 1);
        chk("hlt_instr", 32'(instr), 32'hF000);
        repeat (3) begin
            step();
            chk("hlt_stay_req", 32'(mem_req), 0);
            chk("hlt_stay", 32'(halted), 1);
            chk("hlt_pc", 32'(pc), 32'h14);
        end
        mem_ack = 1'b0;

        reset_n = 1'b0; pc_init = 8'd126;
        step();
        chk("rst2_halted", 32'(halted), 0);
        reset_n = 1'b1;
        step();
        run_instr(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 8'd127);
        mem_ack = 1'b1; mem_rdata = 16'h1000;
        step();
        mem_ack = 1'b0;
        chk("end_halted", 32'(halted), 1);
        chk("end_valid", 32'(instr_valid), 0);
        chk("end_req", 32'(mem_req), 0);

        reset_n = 1'b0; pc_init = 8'd5;
        step();
        reset_n = 1'b1;
        step();
        chk("mid_req", 32'(mem_req), 1);
        chk("mid_addr", 32'(mem_addr), 5);
        step();
        reset_n = 1'b0;
        #1;
        chk("async_req", 32'(mem_req), 0);
        chk("async_hold", 32'(hold), 1);
        chk("async_halted", 32'(halted), 0);
        step();
        reset_n = 1'b1;
        step();
        run_instr(16'h1000, 0, 0, 1'b0, 1'b0, 1'b0, 8'd6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Instruction-fetch sequencer that drives the control inputs of the program counter (`hold`, `jump`, `branch`, `jump_line`, `branch_immem`) and consumes its address output. For each PC value it:

- fetches a 16-bit instruction from instruction memory over a req/ack handshake;
- presents the instruction to the decode/execute stage over a valid/ready handshake;
- decodes control-flow opcodes;
- releases `hold` for exactly one cycle so the PC advances, jumps or branches.

It sits between the PC, instruction memory and the decoder.

## Interface
Parameters:
- `IW`, 16: instruction width.
- `AW`, 8: PC / memory address width.
- `END_ADDR`, 8'd127: end-of-program address; reaching it halts the sequencer.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `pc_addr`  in  AW  current PC value.
- `hold`  out  1  1 = PC frozen.
- `jump`  out  1  PC jump strobe.
- `branch`  out  1  PC branch strobe.
- `jump_line`  out  7  jump target.
- `branch_immem`  out  7  branch target.
- `mem_req`  out  1  instruction memory read request.
- `mem_addr`  out  AW  read address.
- `mem_ack`  in  1  read data valid.
- `mem_rdata`  in  IW  read data.
- `zero_flag`  in  1  ALU zero flag, evaluated for BRZ.
- `instr`  out  IW  instruction to decoder.
- `instr_valid`  out  1  `instr` valid.
- `instr_ready`  in  1  decoder accepts.
- `halted`  out  1  sequencer stopped.

## Operation
FSM states: IDLE, FETCH, ISSUE, ADVANCE, HALT.

- **Reset:** state IDLE. All outputs 0 except `hold`=1.
- **IDLE:**
  - `hold`=1.
  - Next cycle → FETCH.
- **FETCH:**
  - `mem_req`=1, `mem_addr`=`pc_addr`, `hold`=1.
  - `mem_addr` stays stable until `mem_ack`.
  - On `mem_ack`: register `mem_rdata` into `instr`. If opcode is HLT or `pc_addr`==`END_ADDR`, go to HALT; otherwise go to ISSUE.
  - `mem_ack` is ignored in every state other than FETCH.
- **ISSUE:**
  - `instr_valid`=1, `hold`=1; `instr` stable.
  - On `instr_valid && instr_ready`: register the decode result and go to ADVANCE.
  - `zero_flag` is sampled on that same edge.
- **ADVANCE (exactly 1 cycle):**
  - `hold`=0.
  - Opcode 4'hA (JMP): `jump`=1, `jump_line`=`instr[6:0]`.
  - Opcode 4'hB (BRZ): `branch`=`zero_flag` as sampled, `branch_immem`=`instr[6:0]`.
  - Any other opcode: `jump`=`branch`=0.
  - Next state → FETCH.
- **HALT:**
  - `halted`=1, `hold`=1, `instr_valid`=0, `mem_req`=0.
  - Only exit is reset.
- **Decode rules:**
  - Opcode is `instr[15:12]`; HLT = 4'hF.
  - `jump` and `branch` are never both 1.
  - `jump_line`/`branch_immem` hold their last values outside ADVANCE.
- **Reset mid-operation:** asynchronous return to IDLE in any state. An outstanding memory request is abandoned; `mem_req` drops immediately.

## Timing
- All outputs are registered or decoded from state registers only; no combinational input→output paths.
- Minimum 3 cycles per instruction: FETCH with same-cycle `mem_ack`, ISSUE with `instr_ready`=1, ADVANCE.
- PC update: the PC updates on the ADVANCE clock edge. The following FETCH presents the new `pc_addr`.
- Memory latency: unbounded; `mem_req` stays high until acked.
- Backpressure: unbounded; `instr_valid` stays high and `instr` stable until accepted.
- First `mem_req` occurs 1 cycle after `reset_n` deasserts.

## Structure
- Shared package `isa_pkg` holds:
  - opcode constants (JMP=4'hA, BRZ=4'hB, HLT=4'hF);
  - the FSM state enum;
  - the `END_ADDR` default;
  - field-slice constants for opcode `[15:12]` and target `[6:0]`.
- Sub-module `instr_decode`: combinational; inputs `instr` and `zero_flag`, outputs is_jmp, is_brz_taken, is_hlt and target. It is reused by the decoder stage.

## Test plan
- **Reset / first fetch:** hold `reset_n` low, then release → `hold`=1, `mem_req`=0 during reset; `mem_req`=1 with `mem_addr`=`pc_addr` on the 2nd cycle after release.
- **Sequential flow:** `mem_ack` same cycle, `instr_ready`=1, `instr`=16'h1000 at PC 0 → 3-cycle loop; `hold`=0 once per loop; PC sequence 0,1,2,3.
- **Jump:** `instr`=16'hA045 → ADVANCE shows `jump`=1, `jump_line`=7'h45, `branch`=0; next `mem_addr`=8'h45.
- **Branch:** `instr`=16'hB012:
  - with `zero_flag`=1 → `branch`=1, `branch_immem`=7'h12, next `mem_addr`=8'h12;
  - with `zero_flag`=0 → `branch`=0, next `mem_addr`=`pc_addr`+1.
- **Stalls:** `mem_ack` delayed 4 cycles and `instr_ready` delayed 3 cycles → `mem_addr`/`instr` stable throughout; `hold`=1 throughout; exactly one ADVANCE.
- **Halt and reset:**
  - `instr`=16'hF000 → HALT, `halted`=1, no further `mem_req`.
  - `pc_addr`=127 → HALT.
  - Assert `reset_n` low mid-FETCH → immediate IDLE, `mem_req`=0.
